tx_burst_scheduler: RTL and testbench
=====================================

// Module: tx_burst_scheduler
// PURPOSE
//  Sequences one TX burst: on start, sends the configured byte reg_data to the byte
//  transmitter max_tx_count times over a valid/ready handshake, with an optional
//  idle gap between bytes. Sits between the UART command decoder (which supplies
//  max_tx_count/reg_data) and the TX serializer. Reports busy, done, abort status
//  and the number of bytes sent.
// PARAMETERS
//  GAP_CYCLES   0    idle cycles inserted after each accepted byte (0 = back-to-back)
//  GAP_W        16   width of the gap counter; GAP_CYCLES < 2**GAP_W
// PORTS
//  clk           in   1   system clock (25 MHz)
//  rst           in   1   reset, synchronous, active-low
//  start         in   1   one-cycle pulse: begin a burst (ignored unless IDLE)
//  abort         in   1   level/pulse: stop burst after any in-flight byte
//  max_tx_count  in   32  bytes per burst, sampled at start
//  reg_data      in   8   byte value to send, sampled at start
//  tx_ready      in   1   transmitter accepts tx_data this cycle
//  tx_valid      out  1   tx_data valid
//  tx_data       out  8   byte to transmit
//  busy          out  1   high from the cycle after start until DONE exits
//  done          out  1   one-cycle pulse at end of every burst (normal or aborted)
//  aborted       out  1   sticky: last burst ended by abort; cleared in LOAD
//  sent_count    out  32  bytes accepted in current/last burst; held until next start
// BEHAVIOUR
//  Reset (rst==0 at a clk edge): state=IDLE; tx_valid=0, tx_data=8'h00, busy=0,
//   done=0, aborted=0, sent_count=0, internal latches and gap counter cleared.
//   Reset mid-burst discards the burst immediately, no done pulse.
//  States: IDLE, LOAD, SEND, GAP, DONE.
//  IDLE: start=1 && abort=0 -> LOAD. start with abort=1 ignored (abort wins).
//  LOAD (1 cycle): latch cnt_l<=max_tx_count, data_l<=reg_data, sent_count<=0,
//   aborted<=0, busy=1. If max_tx_count==0 or abort=1 -> DONE (zero bytes sent;
//   aborted=1 if abort). Else -> SEND. tx_valid first high 2 cycles after start.
//  SEND: tx_valid=1, tx_data=data_l. Once raised, tx_valid and tx_data hold stable
//   until the edge where tx_valid&&tx_ready (accept). On accept: sent_count+1;
//   if sent_count+1==cnt_l -> DONE; else if abort -> DONE, aborted=1;
//   else GAP_CYCLES>0 -> GAP (tx_valid drops), else stay SEND (valid stays high,
//   next byte back-to-back). Abort without accept does not drop tx_valid.
//  GAP: tx_valid=0; counter runs GAP_CYCLES cycles then -> SEND. abort in GAP ->
//   DONE, aborted=1, no further byte.
//  DONE (1 cycle): done=1, busy=1, tx_valid=0 -> IDLE. busy=0 from next cycle.
//  start while busy (LOAD/SEND/GAP/DONE) ignored, not queued.
//  Config changes on max_tx_count/reg_data after LOAD do not affect the burst.
//  Arithmetic: sent_count 32-bit, compared by equality to cnt_l; never wraps since
//   it stops at cnt_l. max_tx_count=32'hFFFFFFFF is legal.
//  tx_data holds data_l outside SEND (0 until first LOAD after reset).
// TESTING
//  1 max=3, data=8'h9A, GAP=0, tx_ready=1: start -> tx_valid high 3 consecutive
//    cycles from start+2, tx_data=8'h9A, done pulse at start+5, sent_count=3.
//  2 max=2, GAP=4, tx_ready=1 -> accepts at start+2 and start+7, tx_valid low 4
//    cycles between, done at start+8, aborted=0.
//  3 max=0 -> no tx_valid, done at start+2, sent_count=0; max=5 with tx_ready
//    stalled 10 cycles -> tx_valid/tx_data stable throughout stall.
//  4 max=1000, abort pulsed while tx_valid=1 and tx_ready=0 -> byte held until
//    accepted, then done, aborted=1, sent_count=accepted count.
//  5 change reg_data to 8'h55 and max to 9 mid-burst, plus second start -> burst
//    keeps 8'h9A and original count; second start ignored.
//  6 rst=0 mid-SEND -> next cycle all outputs at reset values, no done pulse;
//    start+abort same cycle in IDLE -> stays IDLE.

Source files
------------

// File: rtl/tx_burst_scheduler.sv
// TX burst scheduler: sends a latched byte a latched number of times over a
// valid/ready handshake, with an optional idle gap after each accepted byte.
module tx_burst_scheduler #(
  parameter int unsigned GAP_CYCLES = 0,
  parameter int unsigned GAP_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] max_tx_count,
  input  logic [7:0]  reg_data,
  input  logic        tx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [31:0] sent_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [GAP_W-1:0] GAP_LAST =
    (GAP_CYCLES == 0) ? '0 : GAP_W'(GAP_CYCLES - 1);

  state_t           state_q, state_d;
  logic [31:0]      cnt_l_q, cnt_l_d;
  logic [31:0]      sent_q, sent_d;
  logic [7:0]       data_l_q, data_l_d;
  logic             aborted_q, aborted_d;
  logic             abort_pend_q, abort_pend_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             stop_req;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_l_q      <= '0;
      sent_q       <= '0;
      data_l_q     <= '0;
      aborted_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_l_q      <= cnt_l_d;
      sent_q       <= sent_d;
      data_l_q     <= data_l_d;
      aborted_q    <= aborted_d;
      abort_pend_q <= abort_pend_d;
      gap_q        <= gap_d;
    end
  end

  // An abort seen while a byte is stalled is remembered until that byte is accepted.
  assign stop_req = abort | abort_pend_q;

  always_comb begin
    state_d      = state_q;
    cnt_l_d      = cnt_l_q;
    sent_d       = sent_q;
    data_l_d     = data_l_q;
    aborted_d    = aborted_q;
    abort_pend_d = abort_pend_q;
    gap_d        = gap_q;

    case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start && !abort) state_d = S_LOAD;
      end
      S_LOAD: begin
        cnt_l_d      = max_tx_count;
        data_l_d     = reg_data;
        sent_d       = '0;
        aborted_d    = abort;
        abort_pend_d = 1'b0;
        if (max_tx_count == '0 || abort) state_d = S_DONE;
        else                             state_d = S_SEND;
      end
      S_SEND: begin
        if (tx_ready) begin
          sent_d       = sent_q + 32'd1;
          abort_pend_d = 1'b0;
          if (sent_q + 32'd1 == cnt_l_q) begin
            state_d = S_DONE;
          end else if (stop_req) begin
            state_d   = S_DONE;
            aborted_d = 1'b1;
          end else if (GAP_CYCLES != 0) begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end else if (abort) begin
          abort_pend_d = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = S_SEND;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_DONE: begin
        abort_pend_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tx_valid   = (state_q == S_SEND);
  assign tx_data    = data_l_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign aborted    = aborted_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Bench for tx_burst_scheduler: two instances (no gap / 4-cycle gap) share stimulus;
// a directed table, a few hand sequences, and random bursts against a burst-level model.
module tb_tx_burst_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] max_tx_count = '0;
  logic [7:0]  reg_data = '0;

  logic        vv  [2];
  logic [7:0]  dat [2];
  logic        bb  [2];
  logic        dn  [2];
  logic        ab  [2];
  logic [31:0] sc  [2];

  always #20 clk = ~clk;

  tx_burst_scheduler #(.GAP_CYCLES(0), .GAP_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .max_tx_count(max_tx_count), .reg_data(reg_data), .tx_ready(tx_ready),
    .tx_valid(vv[0]), .tx_data(dat[0]), .busy(bb[0]), .done(dn[0]),
    .aborted(ab[0]), .sent_count(sc[0])
  );

  tx_burst_scheduler #(.GAP_CYCLES(4), .GAP_W(16)) dut4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .max_tx_count(max_tx_count), .reg_data(reg_data), .tx_ready(tx_ready),
    .tx_valid(vv[1]), .tx_data(dat[1]), .busy(bb[1]), .done(dn[1]),
    .aborted(ab[1]), .sent_count(sc[1])
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Burst-level reference: walk bytes in time using the ready pattern, gap length and abort time.
  bit rdy [512];
  bit ev  [2][512];
  int edone [2];
  int ecnt  [2];
  bit eab   [2];
  int abort_at;
  int chg_at;

  task automatic model(input int i, input logic [31:0] n);
    int g, pos, k;
    bit fin;
    g = (i == 0) ? 0 : 4;
    for (int c = 0; c < 512; c++) ev[i][c] = 1'b0;
    eab[i]  = 1'b0;
    ecnt[i] = 0;
    if (n == 0 || abort_at == 1) begin
      edone[i] = 2;
      eab[i]   = (abort_at == 1);
    end else begin
      pos = 2; k = 0; fin = 1'b0;
      while (!fin) begin
        while (!rdy[pos] && pos < 500) begin
          ev[i][pos] = 1'b1;
          pos++;
        end
        ev[i][pos] = 1'b1;
        k++;
        if (n == 32'(k)) begin
          edone[i] = pos + 1; fin = 1'b1;
        end else if (abort_at >= 2 && abort_at <= pos) begin
          edone[i] = pos + 1; eab[i] = 1'b1; fin = 1'b1;
        end else if (abort_at > pos && abort_at <= pos + g) begin
          edone[i] = abort_at + 1; eab[i] = 1'b1; fin = 1'b1;
        end else begin
          pos = pos + g + 1;
          if (pos >= 500) begin
            edone[i] = pos; fin = 1'b1;
          end
        end
      end
      ecnt[i] = k;
    end
  endtask

  task automatic fill_ready(input int zero_until, input int pct);
    for (int c = 0; c < 512; c++)
      rdy[c] = (c >= 300) ? 1'b1 : (c < zero_until) ? 1'b0 : ($urandom_range(0, 99) < pct);
  endtask

  task automatic run_burst(input logic [31:0] n, input logic [7:0] data, input bit rand_chg);
    int len, mind;
    model(0, n);
    model(1, n);
    len  = ((edone[0] > edone[1]) ? edone[0] : edone[1]) + 3;
    mind = (edone[0] < edone[1]) ? edone[0] : edone[1];
    if (rand_chg) chg_at = (mind > 3) ? 2 + $urandom_range(0, mind - 3) : -1;
    for (int rel = 0; rel < len; rel++) begin
      start    = (rel == 0) || (rel == chg_at);
      abort    = (rel == abort_at);
      tx_ready = rdy[rel];
      if (rel == 0) begin
        max_tx_count = n;
        reg_data     = data;
      end
      if (rel == chg_at) begin
        max_tx_count = 32'd9;
        reg_data     = 8'h55;
      end
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid%0d_r%0d", i, rel), 32'(vv[i]), 32'(ev[i][rel]));
        chk($sformatf("done%0d_r%0d", i, rel), 32'(dn[i]), 32'(rel == edone[i]));
        chk($sformatf("busy%0d_r%0d", i, rel), 32'(bb[i]), 32'(rel >= 1 && rel <= edone[i]));
        if (rel >= 2) chk($sformatf("data%0d_r%0d", i, rel), 32'(dat[i]), 32'(data));
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count%0d", i), sc[i], 32'(ecnt[i]));
      chk($sformatf("aborted%0d", i), 32'(ab[i]), 32'(eab[i]));
    end
  endtask

  typedef struct {
    logic [31:0] n;
    logic [7:0]  data;
    int          ab_at;
    int          d0;
    int          c0;
    bit          a0;
    int          d1;
    int          c1;
    bit          a1;
  } vec_t;

  vec_t tbl [8];
  int   got [2];

  initial begin
    // {max, data, abort_at, done/count/aborted for gap 0, same for gap 4}; tx_ready held high
    tbl[0] = '{32'd3,          8'h9A, -1,  5, 3, 1'b0, 13, 3, 1'b0};
    tbl[1] = '{32'd2,          8'h3C, -1,  4, 2, 1'b0,  8, 2, 1'b0};
    tbl[2] = '{32'd0,          8'h11, -1,  2, 0, 1'b0,  2, 0, 1'b0};
    tbl[3] = '{32'd5,          8'h77,  1,  2, 0, 1'b1,  2, 0, 1'b1};
    tbl[4] = '{32'd5,          8'hE1,  3,  4, 2, 1'b1,  4, 1, 1'b1};
    tbl[5] = '{32'd1,          8'hFF,  2,  3, 1, 1'b0,  3, 1, 1'b0};
    tbl[6] = '{32'd4,          8'h0F,  8,  6, 4, 1'b0,  9, 2, 1'b1};
    tbl[7] = '{32'hFFFFFFFF,   8'hA5,  4,  5, 3, 1'b1,  5, 1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_valid%0d", i), 32'(vv[i]), 32'd0);
      chk($sformatf("rst_data%0d", i), 32'(dat[i]), 32'd0);
      chk($sformatf("rst_busy%0d", i), 32'(bb[i]), 32'd0);
      chk($sformatf("rst_done%0d", i), 32'(dn[i]), 32'd0);
      chk($sformatf("rst_aborted%0d", i), 32'(ab[i]), 32'd0);
      chk($sformatf("rst_count%0d", i), sc[i], 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 8; t++) begin
      got[0] = -1; got[1] = -1;
      for (int rel = 0; rel < 20; rel++) begin
        start    = (rel == 0);
        abort    = (rel == tbl[t].ab_at);
        tx_ready = 1'b1;
        if (rel == 0) begin
          max_tx_count = tbl[t].n;
          reg_data     = tbl[t].data;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          if (dn[i] && got[i] < 0) got[i] = rel;
          if (vv[i]) chk($sformatf("tbl%0d_data%0d", t, i), 32'(dat[i]), 32'(tbl[t].data));
        end
        @(posedge clk); #1;
      end
      start = 1'b0; abort = 1'b0;
      chk($sformatf("tbl%0d_done0", t), 32'(got[0]), 32'(tbl[t].d0));
      chk($sformatf("tbl%0d_count0", t), sc[0], 32'(tbl[t].c0));
      chk($sformatf("tbl%0d_aborted0", t), 32'(ab[0]), 32'(tbl[t].a0));
      chk($sformatf("tbl%0d_done1", t), 32'(got[1]), 32'(tbl[t].d1));
      chk($sformatf("tbl%0d_count1", t), sc[1], 32'(tbl[t].c1));
      chk($sformatf("tbl%0d_aborted1", t), 32'(ab[1]), 32'(tbl[t].a1));
    end

    // tx_ready stalled for 10 cycles of the first byte
    abort_at = -1; chg_at = -1;
    fill_ready(12, 100);
    run_burst(32'd5, 8'h9A, 1'b0);

    // long burst, abort pulse while stalled: byte held, then burst ends aborted
    abort_at = 4; chg_at = -1;
    fill_ready(9, 100);
    run_burst(32'd1000, 8'h9A, 1'b0);

    // config change plus second start mid-burst must not disturb the burst
    abort_at = -1; chg_at = 3;
    fill_ready(0, 100);
    run_burst(32'd4, 8'h9A, 1'b0);

    // reset mid-SEND, then start together with abort in IDLE
    max_tx_count = 32'd10; reg_data = 8'h5A; tx_ready = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("pre_rst_valid", 32'(vv[0]), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("mid_rst_valid%0d", i), 32'(vv[i]), 32'd0);
      chk($sformatf("mid_rst_data%0d", i), 32'(dat[i]), 32'd0);
      chk($sformatf("mid_rst_busy%0d", i), 32'(bb[i]), 32'd0);
      chk($sformatf("mid_rst_aborted%0d", i), 32'(ab[i]), 32'd0);
      chk($sformatf("mid_rst_count%0d", i), sc[i], 32'd0);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) chk($sformatf("mid_rst_done%0d_c%0d", i, c), 32'(dn[i]), 32'd0);
    end
    @(posedge clk); #1;
    start = 1'b1; abort = 1'b1; max_tx_count = 32'd3;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("start_abort_busy%0d_c%0d", i, c), 32'(bb[i]), 32'd0);
        chk($sformatf("start_abort_valid%0d_c%0d", i, c), 32'(vv[i]), 32'd0);
      end
    end
    @(posedge clk); #1;

    for (int b = 0; b < 30; b++) begin
      abort_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : -1;
      chg_at   = -1;
      fill_ready(0, 70);
      run_burst(32'($urandom_range(0, 8)), 8'($urandom), ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
